// File: rtl/sent_tx_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module   : sent_tx_pulse_gen
// Purpose  : SENT transmitter physical-layer symbol generator. It turns
//            per-symbol requests (sync / pause / pulse + nibble) into the
//            single-wire SENT waveform and returns the pulse_done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module sent_tx_pulse_gen #(
  parameter int TICK_DIV    = 3,   // clk_tx cycles per SENT tick
  parameter int LOW_TICKS   = 5,   // low-phase length of every symbol (ticks)
  parameter int PAUSE_TICKS = 12,  // pause pulse length (ticks)
  parameter int DONE_LEAD   = 4    // pulse_done lead before symbol end (clocks)
) (
  input  logic       clk_tx,
  input  logic       reset_tx,     // asynchronous, active-low
  input  logic       sync,
  input  logic       pause,
  input  logic       pulse,
  input  logic       idle,
  input  logic [3:0] data_nibble,
  output logic       sent_out,
  output logic       pulse_done,
  output logic       busy,
  output logic       tick
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SYM_SYNC  = 2'd1,
    SYM_NIB   = 2'd2,
    SYM_PAUSE = 2'd3
  } state_t;

  localparam logic [15:0] c_DIV         = 16'(TICK_DIV);
  localparam logic [15:0] c_DIV_LAST    = 16'(TICK_DIV - 1);
  localparam logic [15:0] c_LOW_CLKS    = 16'(LOW_TICKS * TICK_DIV);
  localparam logic [15:0] c_DONE_LEAD   = 16'(DONE_LEAD);
  localparam logic [15:0] c_SYNC_TICKS  = 16'd56;
  localparam logic [15:0] c_NIB_BASE    = 16'd12;
  localparam logic [15:0] c_PAUSE_TICKS = 16'(PAUSE_TICKS);

  state_t      r_state, w_state_nxt, w_dec_state;
  logic [15:0] r_cnt, w_cnt_nxt;          // clocks remaining in symbol, minus one
  logic [15:0] r_elapsed, w_elapsed_nxt;  // clocks elapsed in symbol
  logic [15:0] r_pre, w_pre_nxt;          // tick prescaler
  logic        r_out, w_out_nxt;
  logic        r_done, w_done_nxt;
  logic [15:0] w_len_ticks;
  logic [15:0] w_len_clks;
  logic        w_boundary;

  // Request decode: idle blocks everything, then sync > pause > pulse.
  // The nibble is folded into the loaded length here, so holding the
  // counter holds the captured nibble for the whole symbol.
  always_comb begin
    w_dec_state = IDLE;
    w_len_ticks = 16'd0;
    if (!idle) begin
      if (sync) begin
        w_dec_state = SYM_SYNC;
        w_len_ticks = c_SYNC_TICKS;
      end else if (pause) begin
        w_dec_state = SYM_PAUSE;
        w_len_ticks = c_PAUSE_TICKS;
      end else if (pulse) begin
        w_dec_state = SYM_NIB;
        w_len_ticks = c_NIB_BASE + {12'd0, data_nibble};
      end
    end
    w_len_clks = w_len_ticks * c_DIV;
    w_boundary = (r_state == IDLE) || (r_cnt == 16'd0);
  end

  // Next-state and next-output logic; outputs are computed one clock
  // ahead so that sent_out and pulse_done come straight from flops.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_elapsed_nxt = r_elapsed;
    w_pre_nxt     = r_pre;
    w_out_nxt     = 1'b1;
    w_done_nxt    = 1'b0;
    if (w_boundary) begin
      w_state_nxt   = w_dec_state;
      w_elapsed_nxt = 16'd0;
      w_pre_nxt     = 16'd0;
      if (w_dec_state != IDLE) begin
        w_cnt_nxt = w_len_clks - 16'd1;
        w_out_nxt = 1'b0;
      end else begin
        w_cnt_nxt = 16'd0;
      end
    end else begin
      w_cnt_nxt     = r_cnt - 16'd1;
      w_elapsed_nxt = r_elapsed + 16'd1;
      w_pre_nxt     = (r_pre == c_DIV_LAST) ? 16'd0 : r_pre + 16'd1;
      w_out_nxt     = !((r_elapsed + 16'd1) < c_LOW_CLKS);
      w_done_nxt    = (r_cnt == c_DONE_LEAD);
    end
  end

  // State, counters and registered line outputs.
  always_ff @(posedge clk_tx or negedge reset_tx) begin
    if (!reset_tx) begin
      r_state   <= IDLE;
      r_cnt     <= 16'd0;
      r_elapsed <= 16'd0;
      r_pre     <= 16'd0;
      r_out     <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_elapsed <= w_elapsed_nxt;
      r_pre     <= w_pre_nxt;
      r_out     <= w_out_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign sent_out   = r_out;
  assign pulse_done = r_done;
  assign busy       = (r_state != IDLE);
  assign tick       = busy && (r_pre == c_DIV_LAST);

endmodule
`default_nettype wire

// File: doc/sent_tx_pulse_gen.md
# sent_tx_pulse_gen

Physical-layer symbol generator of the SENT transmitter. It sits directly downstream of `sent_tx_control`. It turns that block's per-symbol requests (`sync`, `pulse` with `data_nibble`, `pause`) into the single-wire SENT waveform on `sent_out`. It returns the `pulse_done` handshake that advances the control FSM. Symbol lengths are counted in SENT ticks derived from `clk_tx` by an internal prescaler.

## Interface
- `TICK_DIV`, default 3: `clk_tx` cycles per SENT tick, ≥1.
- `LOW_TICKS`, default 5: low-phase length of every symbol, in ticks, 4..11.
- `PAUSE_TICKS`, default 12: pause-pulse length in ticks, 12..768.
- `DONE_LEAD`, default 4: `pulse_done` fires this many `clk_tx` cycles before the symbol ends, ≥4, < 12*`TICK_DIV`.
- `clk_tx`, in, 1: the block's single clock. All logic is on the rising edge.
- `reset_tx`, in, 1: asynchronous, active-low reset.
- `sync`, in, 1: request a sync/calibration pulse.
- `pause`, in, 1: request a pause pulse.
- `pulse`, in, 1: request a data nibble pulse.
- `idle`, in, 1: transmission finished. Blocks new symbol starts.
- `data_nibble`, in, 4: nibble value for a `pulse` symbol.
- `sent_out`, out, 1: SENT line. High is recessive.
- `pulse_done`, out, 1: one-cycle strobe ahead of the symbol end.
- `busy`, out, 1: high while a symbol is on the line.
- `tick`, out, 1: one-cycle strobe on each SENT tick boundary while busy (debug).

## Operation
- **Reset values:** `sent_out`=1, `pulse_done`=0, `busy`=0, `tick`=0. FSM is in IDLE; all counters are 0.
- **Symbol length L, in ticks:**
  - SYNC = 56.
  - NIBBLE = 12 + `data_nibble`, i.e. 12..27.
  - PAUSE = `PAUSE_TICKS`.
- **Length in clocks:** Lc = L*`TICK_DIV`. The symbol clock counter is 16 bits and loads Lc - 1, then counts down to 0.
- **Symbol waveform:**
  - `sent_out` is low for the first `LOW_TICKS`*`TICK_DIV` clocks of every symbol, then high for the rest.
  - Symbols are back-to-back. The falling edge of the next symbol is on the clock immediately after the last clock of the current one.
- **FSM states:** IDLE, SYM_SYNC, SYM_NIB, SYM_PAUSE.
- **Request decode:**
  - Used when starting from IDLE, and at the last clock of any symbol (the boundary).
  - Priority: `sync` > `pause` > `pulse`.
  - `idle`=1 or no request: go to / stay in IDLE, `sent_out`=1.
  - `data_nibble` is captured at the boundary decode and held for the whole symbol.
- **`pulse_done`:**
  - High for exactly one clock, when the remaining-clock count equals `DONE_LEAD` - 1. That is clock Lc - `DONE_LEAD` of the symbol, counting from 0.
  - The control FSM detects the falling edge and needs 3 cycles to present the next request. `DONE_LEAD`≥4 guarantees the next request is stable at the boundary decode.
- **IDLE → symbol:** the first cycle with a request and `idle`=0 starts the symbol on the next clock. The prescaler restarts at that point.
- **`tick`:** pulses on each prescaler wrap (every `TICK_DIV` clocks) while `busy`=1.
- **Boundary conditions:**
  - Request inputs changing mid-symbol are ignored; only the decode points sample them.
  - Simultaneous `sync` and `pulse`: SYNC is sent.
  - `data_nibble` changing mid-symbol has no effect.
  - Reset asserted mid-symbol: `sent_out` goes high asynchronously, `pulse_done` goes to 0, no partial-symbol completion.
  - `busy` drops in the cycle IDLE is entered.

## Timing
- Start latency: request high in cycle n → `sent_out` low from cycle n+1.
- Boundary: last high clock at cycle s+Lc-1 → next falling edge at cycle s+Lc (zero gap).
- `pulse_done` to boundary: exactly `DONE_LEAD` clocks, including the strobe cycle.
- `sent_out` and `pulse_done` are registered outputs, with no combinational path from the inputs.

## Test plan
All scenarios use default parameters.
- **Nibble 0x7:** `pulse`=1 from IDLE, `data_nibble`=7 → 57-clock symbol, 15 clocks low, 42 high. `pulse_done` at clock 53. `tick` count 19.
- **Sync:** `sync`=1 from IDLE → 168 clocks, 15 low, 153 high. `pulse_done` at clock 164.
- **Frame chaining with `sent_tx_control` model:**
  - Stimulus: SYNC, status 0x8, data 0x0/0xF, CRC.
  - Required lengths: 168, 60, 36, 81, and the CRC length.
  - No gap between symbols.
  - Nibble values on the line match `data_nibble` sampled at each boundary.
- **Priority:** `sync`=`pulse`=`pause`=1 at the boundary → SYNC. `pause`+`pulse` → PAUSE of 36 clocks. Changing `data_nibble` mid-symbol does not alter the length.
- **End of transmission:** `idle`=1 and all requests 0 at the boundary → `sent_out` stays 1, `busy`=0, no further `pulse_done`.
- **Reset mid-symbol:** `reset_tx`=0 during the low phase → `sent_out`=1 immediately. After release with no request, the block stays in IDLE; the next `pulse` starts a full-length symbol.
